decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline decode stage: splits a 24-bit instruction into opcode, destination and source register addresses, and an immediate.
- Reads two source operands from an internal 8 x WIDTH register file.
- Accepts the write-back port from the later stage.
- Sits between fetch (instruction, PC) and execute (operands, immediate, addresses, opcode).

Parameters:
WIDTH, 32, data/register width
REGNUM, 8, number of registers
ADDRESSWIDTH, 3, register address width (log2 REGNUM)
OPCODEWIDTH, 4, opcode width
INSTRUCTIONWIDTH, 24, instruction width

Ports:
clk  input  1  single clock, rising-edge active
reset  input  1  asynchronous, active-low reset
writeA  input  ADDRESSWIDTH  write-back register address
dataToSave  input  WIDTH  write-back data
PC  input  WIDTH  current PC; carried for interface compatibility, no functional effect in this block
instruction  input  INSTRUCTIONWIDTH  instruction to decode
writeE  input  1  write-back enable
rd1D  output  WIDTH  data of register r1A
rd2D  output  WIDTH  data of register r2A
inmediate  output  WIDTH  zero-extended immediate
regDestinationAddress  output  ADDRESSWIDTH  destination register
r1A  output  ADDRESSWIDTH  source register 1
r2A  output  ADDRESSWIDTH  source register 2
opcode  output  OPCODEWIDTH  operation code

Behaviour:
- Instruction format, 4-bit nibble fields:
  - [23:20] opcode
  - [19:16] rd
  - [15:12] rs1
  - [11:8] rs2
  - [7:0] spare
- Register address = low ADDRESSWIDTH bits of each field:
  - regDestinationAddress = instruction[18:16]
  - r1A = instruction[14:12]
  - r2A = instruction[10:8]
- inmediate = {zeros, instruction[15:0]}, zero-extended to WIDTH.
- All field outputs are purely combinational from instruction; zero latency.
- Register file: REGNUM x WIDTH.
  - Write: dataToSave to reg[writeA] on rising clk when writeE=1 and reset=1.
  - writeE=0: no change.
- Reads are combinational (rd1D = reg[r1A], rd2D = reg[r2A]), with write-through bypass:
  - If writeE=1 and writeA equals the read address, the read returns dataToSave in the same cycle.
  - The bypass applies to each read port independently.
- Reset (reset=0): asynchronously clears all registers to 0.
  - While reset is low, rd1D and rd2D read 0 and the bypass is disabled.
  - Field outputs still follow instruction.
  - Reset mid-operation overrides any write in that cycle.
- Register 0 is an ordinary writable register (not hardwired zero).
- writeA and writeE are don't-care-safe: X on writeA with writeE=0 causes no write.

Decomposition:
- Package decode_pkg: field bit positions (OP_MSB=23, RD_MSB=19, RS1_MSB=15, RS2_MSB=11, IMM_MSB=15) and default widths.
- One sub-module: register_file (async active-low clear, 1 write port, 2 combinational read ports with bypass).
- The field splitter stays inline in decode_stage.

Test Plan:
- Reset low, then instruction 0x501200 -> opcode=4'b0101, regDestinationAddress=0, r1A=1, r2A=2, rd1D=rd2D=0, inmediate=0x00001200.
- Release reset; writeE=1, writeA=1, dataToSave=1; clock edge; writeE=0 -> with 0x501200, rd1D=1, rd2D=0.
- Same-cycle bypass: writeE=1, writeA=2, dataToSave=0xDEADBEEF, instruction 0x501200 -> rd2D=0xDEADBEEF before the clock edge; still 0xDEADBEEF after the edge with writeE=0.
- Instruction 0x656700 (MOD r5,r6,r7) -> opcode=4'b0110, regDestinationAddress=5, r1A=6, r2A=7, inmediate=0x00006700.
- writeE=0 with writeA=3, dataToSave=5, clocked -> reg3 remains 0 (read via instruction 0x003300: rd1D=rd2D=0).
- Registers loaded, then reset pulsed low between clock edges -> rd1D/rd2D drop to 0 immediately; no write on the following edge while reset is low.

Source files
------------

// File: rtl/decode_pkg.sv
// Purpose: shared field positions and default widths for the decode stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Instructions are built from 4-bit nibble fields. Register addresses use the
// low bits of their nibble, so each field's LSB is derived from its MSB.
package decode_pkg;

  localparam int FIELD_W = 4;

  localparam int OP_MSB  = 23;
  localparam int RD_MSB  = 19;
  localparam int RS1_MSB = 15;
  localparam int RS2_MSB = 11;
  localparam int IMM_MSB = 15;

  localparam int RD_LSB  = RD_MSB  - FIELD_W + 1;
  localparam int RS1_LSB = RS1_MSB - FIELD_W + 1;
  localparam int RS2_LSB = RS2_MSB - FIELD_W + 1;
  localparam int IMM_W   = IMM_MSB + 1;

  localparam int DEF_WIDTH            = 32;
  localparam int DEF_REGNUM           = 8;
  localparam int DEF_ADDRESSWIDTH     = 3;
  localparam int DEF_OPCODEWIDTH      = 4;
  localparam int DEF_INSTRUCTIONWIDTH = 24;

endpackage

// File: rtl/register_file.sv
// Purpose: REGNUM x WIDTH register file with one write port and two read ports.
// Latency: writes land on the rising clk edge; reads are combinational, with
//          same-cycle write-through bypass.
// Backpressure: none; every write with i_we=1 is accepted.
//
// Ports:
//   clk, rst_n        clock, async active-low clear of every register
//   i_we, i_wa, i_wd  write enable / address / data
//   i_ra1, i_ra2      read addresses
//   o_rd1, o_rd2      read data (0 while in reset)
module register_file
  import decode_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int REGNUM       = DEF_REGNUM,
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [ADDRESSWIDTH-1:0] i_wa,
  input  logic [WIDTH-1:0]        i_wd,
  input  logic [ADDRESSWIDTH-1:0] i_ra1,
  input  logic [ADDRESSWIDTH-1:0] i_ra2,
  output logic [WIDTH-1:0]        o_rd1,
  output logic [WIDTH-1:0]        o_rd2
);

  logic [WIDTH-1:0] r_regs [REGNUM];

  // The async clear also wins over a write attempted while reset is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGNUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Bypass compares gate on i_we first, so an unknown address with the
  // enable low cannot leak the write data onto a read port.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (rst_n) begin
      o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_regs[i_ra1];
      o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_regs[i_ra2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Purpose: splits an instruction into opcode/rd/rs1/rs2/immediate and reads
//          both source operands from the register file.
// Latency: zero (fields and reads are combinational); write-back lands on clk.
// Backpressure: none.
//
// Ports:
//   clk, reset                    clock, async active-low reset
//   writeA, dataToSave, writeE    write-back port from the later stage
//   PC                            carried for interface compatibility only
//   instruction                   instruction to decode
//   rd1D, rd2D                    operands for r1A / r2A
//   inmediate                     zero-extended instruction[15:0]
//   regDestinationAddress, r1A, r2A, opcode   decoded fields
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int REGNUM           = DEF_REGNUM,
  parameter int ADDRESSWIDTH     = DEF_ADDRESSWIDTH,
  parameter int OPCODEWIDTH      = DEF_OPCODEWIDTH,
  parameter int INSTRUCTIONWIDTH = DEF_INSTRUCTIONWIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDRESSWIDTH-1:0]     writeA,
  input  logic [WIDTH-1:0]            dataToSave,
  input  logic [WIDTH-1:0]            PC,
  input  logic [INSTRUCTIONWIDTH-1:0] instruction,
  input  logic                        writeE,
  output logic [WIDTH-1:0]            rd1D,
  output logic [WIDTH-1:0]            rd2D,
  output logic [WIDTH-1:0]            inmediate,
  output logic [ADDRESSWIDTH-1:0]     regDestinationAddress,
  output logic [ADDRESSWIDTH-1:0]     r1A,
  output logic [ADDRESSWIDTH-1:0]     r2A,
  output logic [OPCODEWIDTH-1:0]      opcode
);

  logic [ADDRESSWIDTH-1:0] w_rd_addr;
  logic [ADDRESSWIDTH-1:0] w_rs1_addr;
  logic [ADDRESSWIDTH-1:0] w_rs2_addr;

  // Register addresses take only the low bits of each nibble field.
  assign opcode     = instruction[OP_MSB -: OPCODEWIDTH];
  assign w_rd_addr  = instruction[RD_LSB  +: ADDRESSWIDTH];
  assign w_rs1_addr = instruction[RS1_LSB +: ADDRESSWIDTH];
  assign w_rs2_addr = instruction[RS2_LSB +: ADDRESSWIDTH];
  assign inmediate  = {{(WIDTH-IMM_W){1'b0}}, instruction[IMM_MSB:0]};

  assign regDestinationAddress = w_rd_addr;
  assign r1A                   = w_rs1_addr;
  assign r2A                   = w_rs2_addr;

  // PC and the top bit of the rd nibble have no function in this stage.
  logic w_unused;
  assign w_unused = ^{PC, instruction[RD_MSB]};

  register_file #(
    .WIDTH        (WIDTH),
    .REGNUM       (REGNUM),
    .ADDRESSWIDTH (ADDRESSWIDTH)
  ) u_regfile (
    .clk   (clk),
    .rst_n (reset),
    .i_we  (writeE),
    .i_wa  (writeA),
    .i_wd  (dataToSave),
    .i_ra1 (w_rs1_addr),
    .i_ra2 (w_rs2_addr),
    .o_rd1 (rd1D),
    .o_rd2 (rd2D)
  );

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [2:0]  writeA;
  logic [31:0] dataToSave;
  logic [31:0] PC;
  logic [23:0] instruction;
  logic        writeE;
  logic [31:0] rd1D, rd2D, inmediate;
  logic [2:0]  regDestinationAddress, r1A, r2A;
  logic [3:0]  opcode;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  logic [31:0] mdl [8];

  decode_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .writeA                (writeA),
    .dataToSave            (dataToSave),
    .PC                    (PC),
    .instruction           (instruction),
    .writeE                (writeE),
    .rd1D                  (rd1D),
    .rd2D                  (rd2D),
    .inmediate             (inmediate),
    .regDestinationAddress (regDestinationAddress),
    .r1A                   (r1A),
    .r2A                   (r2A),
    .opcode                (opcode)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference register contents: cleared by reset, written on edges.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) mdl[i] = 32'd0;
    end else if (writeE) begin
      mdl[writeA] = dataToSave;
    end
  end

  function automatic logic [31:0] exp_read(input int a);
    if (!reset) return 32'd0;
    if (writeE && (int'(writeA) == a)) return dataToSave;
    return mdl[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t instr=%h)", nm, act, exp, $time, instruction);
    end
  endtask

  task automatic check_all();
    int op, rd, s1, s2;
    op = (int'(instruction) >> 20) & 15;
    rd = (int'(instruction) >> 16) & 7;
    s1 = (int'(instruction) >> 12) & 7;
    s2 = (int'(instruction) >> 8) & 7;
    chk("opcode", 32'(opcode), 32'(op));
    chk("rd",     32'(regDestinationAddress), 32'(rd));
    chk("r1A",    32'(r1A), 32'(s1));
    chk("r2A",    32'(r2A), 32'(s2));
    chk("imm",    inmediate, 32'(instruction) & 32'h0000FFFF);
    chk("rd1D",   rd1D, exp_read(s1));
    chk("rd2D",   rd2D, exp_read(s2));
  endtask

  always @(negedge clk) if (chk_en) check_all();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; writeE = 0; writeA = 0; dataToSave = 0; PC = 0;
    instruction = 24'h501200;
    #3;
    chk("rst_opcode", 32'(opcode), 32'h5);
    chk("rst_rd",     32'(regDestinationAddress), 32'd0);
    chk("rst_r1A",    32'(r1A), 32'd1);
    chk("rst_r2A",    32'(r2A), 32'd2);
    chk("rst_rd1D",   rd1D, 32'd0);
    chk("rst_rd2D",   rd2D, 32'd0);
    chk("rst_imm",    inmediate, 32'h00001200);

    // First write after reset release.
    step();
    reset = 1; chk_en = 1;
    writeE = 1; writeA = 3'd1; dataToSave = 32'd1;
    step();
    writeE = 0;
    #2;
    chk("wr1_rd1D", rd1D, 32'd1);
    chk("wr1_rd2D", rd2D, 32'd0);

    // Same-cycle bypass on port 2 before the edge, then stored after it.
    writeE = 1; writeA = 3'd2; dataToSave = 32'hDEADBEEF;
    #1;
    chk("byp_rd2D", rd2D, 32'hDEADBEEF);
    chk("byp_rd1D", rd1D, 32'd1);
    step();
    writeE = 0;
    #2;
    chk("stored_rd2D", rd2D, 32'hDEADBEEF);

    instruction = 24'h656700;
    #1;
    chk("mod_opcode", 32'(opcode), 32'h6);
    chk("mod_rd",     32'(regDestinationAddress), 32'd5);
    chk("mod_r1A",    32'(r1A), 32'd6);
    chk("mod_r2A",    32'(r2A), 32'd7);
    chk("mod_imm",    inmediate, 32'h00006700);

    // Disabled write leaves reg3 alone.
    step();
    writeE = 0; writeA = 3'd3; dataToSave = 32'd5; instruction = 24'h003300;
    step();
    #2;
    chk("nowr_rd1D", rd1D, 32'd0);
    chk("nowr_rd2D", rd2D, 32'd0);

    // Unknown write address with enable low must not write.
    step();
    writeA = 'x; writeE = 0; dataToSave = 32'h12345678; instruction = 24'h501200;
    step();
    writeA = 3'd0;
    #2;
    chk("xaddr_rd1D", rd1D, 32'd1);
    chk("xaddr_rd2D", rd2D, 32'hDEADBEEF);

    // Reset pulsed between edges: reads drop immediately, no bypass, no write.
    step();
    reset = 0;
    #1;
    chk("midrst_rd1D", rd1D, 32'd0);
    chk("midrst_rd2D", rd2D, 32'd0);
    writeE = 1; writeA = 3'd1; dataToSave = 32'd77;
    #1;
    chk("midrst_nobyp", rd1D, 32'd0);
    step();
    writeE = 0;
    step();
    reset = 1;
    #2;
    chk("postrst_rd1D", rd1D, 32'd0);
    chk("postrst_rd2D", rd2D, 32'd0);

    // Randomized traffic checked every cycle by the compare process.
    for (int n = 0; n < 600; n++) begin
      step();
      instruction = 24'($urandom);
      writeE      = 1'($urandom_range(0, 1));
      dataToSave  = $urandom;
      PC          = $urandom;
      if ($urandom_range(0, 2) == 0)
        writeA = 3'((int'(instruction) >> 12) & 7);
      else
        writeA = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 39) != 0);
    end
    step();
    reset = 1; writeE = 0;
    step();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
